hsel_slave_responder: RTL and testbench

Slave-side responder for the decoded 16-bit request bus. A request word is a 3-bit slave ID in [15:13] and a 13-bit payload in [12:0]; the address decoder converts the ID into a one-hot `hsel_*` strobe. This block sits on one `hsel_*` line. It captures the selected word, inserts a programmable number of wait states, and services a read or write on a 4-entry, 10-bit register bank. It completes each transfer with a one-cycle `hready` pulse and an `hresp` error flag.

---
 rtl/hsel_slave_responder.sv | 150 +++++++++++++++
 tb/tb_hsel_slave_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hsel_slave_responder.sv
// hsel_slave_responder
// Slave-side responder sitting on one decoded hsel line. Captures the request
// word when selected, waits WAIT_CYCLES wait states, then answers with a
// one-cycle hready pulse carrying hresp/rdata. Holds a 4-entry, 10-bit bank:
// entries 0..2 are read/write, entry 3 is read-only and returns SLAVE_ID.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   hsel     in   select strobe, qualifies data_in
//   data_in  in   [15:13] id, [12] write, [11:10] index, [9:0] write data
//   hready   out  one-cycle completion pulse
//   hresp    out  error flag, nonzero only with hready
//   rdata    out  read data, nonzero only with hready
//   busy     out  transfer in progress (WAIT or RESP)
module hsel_slave_responder #(
  parameter logic [2:0]  SLAVE_ID    = 3'd1,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [15:0] data_in,
  output logic        hready,
  output logic        hresp,
  output logic [9:0]  rdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES[3:0];

  logic [1:0]  state_r;
  logic [3:0]  cnt_r;
  logic [15:0] req_r;
  logic [9:0]  regs_r [0:2];

  logic        hready_r;
  logic        hresp_r;
  logic [9:0]  rdata_r;
  logic        busy_r;

  logic [2:0]  req_id_s;
  logic        req_wr_s;
  logic [1:0]  req_idx_s;
  logic        req_err_s;
  logic [9:0]  reg_val_s;
  logic [9:0]  resp_data_s;

  // Decode the latched request: error status and the data to return.
  always_comb begin
    req_id_s    = req_r[15:13];
    req_wr_s    = req_r[12];
    req_idx_s   = req_r[11:10];
    req_err_s   = (req_id_s != SLAVE_ID) || (req_wr_s && (req_idx_s == 2'd3));
    reg_val_s   = 10'd0;
    case (req_idx_s)
      2'd0:    reg_val_s = regs_r[0];
      2'd1:    reg_val_s = regs_r[1];
      2'd2:    reg_val_s = regs_r[2];
      2'd3:    reg_val_s = {7'd0, SLAVE_ID};
      default: reg_val_s = 10'd0;
    endcase
    if (req_err_s || req_wr_s) begin
      resp_data_s = 10'd0;
    end else begin
      resp_data_s = reg_val_s;
    end
  end

  // Transfer FSM; response outputs are loaded on the edge that enters RESP
  // so they are valid for exactly the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      req_r    <= 16'd0;
      hready_r <= 1'b0;
      hresp_r  <= 1'b0;
      rdata_r  <= 10'd0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hsel) begin
            req_r   <= data_in;
            cnt_r   <= WAIT_LOAD;
            state_r <= ST_WAIT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r  <= ST_RESP;
            hready_r <= 1'b1;
            hresp_r  <= req_err_s;
            rdata_r  <= resp_data_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r  <= ST_IDLE;
          hready_r <= 1'b0;
          hresp_r  <= 1'b0;
          rdata_r  <= 10'd0;
          busy_r   <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= 4'd0;
          hready_r <= 1'b0;
          hresp_r  <= 1'b0;
          rdata_r  <= 10'd0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  // Register bank update: committed on the edge leaving RESP, only for an
  // error-free write (which also guarantees the index is 0..2).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_r[0] <= 10'd0;
      regs_r[1] <= 10'd0;
      regs_r[2] <= 10'd0;
    end else if ((state_r == ST_RESP) && req_wr_s && !req_err_s) begin
      case (req_idx_s)
        2'd0:    regs_r[0] <= req_r[9:0];
        2'd1:    regs_r[1] <= req_r[9:0];
        2'd2:    regs_r[2] <= req_r[9:0];
        default: regs_r[0] <= regs_r[0];
      endcase
    end else begin
      regs_r[0] <= regs_r[0];
    end
  end

  assign hready = hready_r;
  assign hresp  = hresp_r;
  assign rdata  = rdata_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_hsel_slave_responder.sv
// Scoreboard bench for hsel_slave_responder: instance a uses W=2, instance b
// uses W=0. Stimulus pushes the expected response (flag, data, cycle) at the
// capture edge; per-instance monitors pop and compare on every hready.
module tb_hsel_slave_responder;

  typedef struct {
    logic       resp;
    logic [9:0] rdata;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsel_a = 1'b0, hsel_b = 1'b0;
  logic [15:0] data_a = 16'd0, data_b = 16'd0;
  logic        hready_a, hresp_a, busy_a, hready_b, hresp_b, busy_b;
  logic [9:0]  rdata_a, rdata_b;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  hsel_slave_responder #(.SLAVE_ID(3'd1), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .hsel(hsel_a), .data_in(data_a),
    .hready(hready_a), .hresp(hresp_a), .rdata(rdata_a), .busy(busy_a));

  hsel_slave_responder #(.SLAVE_ID(3'd1), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .hsel(hsel_b), .data_in(data_b),
    .hready(hready_b), .hresp(hresp_b), .rdata(rdata_b), .busy(busy_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for instance a
  always @(negedge clk) begin
    exp_t e;
    if (hready_a === 1'b1) begin
      n_vec++;
      if (q_a.size() == 0) begin
        n_err++;
        $display("FAIL a_unexpected_hready cyc=%0d resp=%b rdata=%h", cyc, hresp_a, rdata_a);
      end else begin
        e = q_a.pop_front();
        if (hresp_a !== e.resp || rdata_a !== e.rdata || cyc != e.due) begin
          n_err++;
          $display("FAIL a_resp got resp=%b rdata=%h cyc=%0d want resp=%b rdata=%h cyc=%0d",
                   hresp_a, rdata_a, cyc, e.resp, e.rdata, e.due);
        end
      end
    end else if (hresp_a !== 1'b0 || rdata_a !== 10'd0) begin
      n_err++;
      $display("FAIL a_idle_outputs cyc=%0d resp=%b rdata=%h want 0 0", cyc, hresp_a, rdata_a);
    end
  end

  // Monitor for instance b
  always @(negedge clk) begin
    exp_t e;
    if (hready_b === 1'b1) begin
      n_vec++;
      if (q_b.size() == 0) begin
        n_err++;
        $display("FAIL b_unexpected_hready cyc=%0d resp=%b rdata=%h", cyc, hresp_b, rdata_b);
      end else begin
        e = q_b.pop_front();
        if (hresp_b !== e.resp || rdata_b !== e.rdata || cyc != e.due) begin
          n_err++;
          $display("FAIL b_resp got resp=%b rdata=%h cyc=%0d want resp=%b rdata=%h cyc=%0d",
                   hresp_b, rdata_b, cyc, e.resp, e.rdata, e.due);
        end
      end
    end else if (hresp_b !== 1'b0 || rdata_b !== 10'd0) begin
      n_err++;
      $display("FAIL b_idle_outputs cyc=%0d resp=%b rdata=%h want 0 0", cyc, hresp_b, rdata_b);
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input bit which, input logic resp, input logic [9:0] rd);
    exp_t e;
    e.resp  = resp;
    e.rdata = rd;
    e.due   = cyc + (which ? 1 : 3);
    if (which) q_b.push_back(e); else q_a.push_back(e);
  endtask

  // One isolated transfer: drive for one capture edge, then measure the busy
  // period and require the response to have been consumed.
  task automatic xfer(input bit which, input logic [15:0] w, input logic resp,
                      input logic [9:0] rd);
    int nb;
    int guard;
    @(negedge clk);
    if (which) begin hsel_b = 1'b1; data_b = w; end
    else       begin hsel_a = 1'b1; data_a = w; end
    @(posedge clk);
    #1;
    push(which, resp, rd);
    hsel_a = 1'b0; hsel_b = 1'b0; data_a = 16'd0; data_b = 16'd0;
    nb = 0;
    guard = 0;
    @(negedge clk);
    while (((which ? busy_b : busy_a) === 1'b1) && guard < 30) begin
      nb++;
      guard++;
      @(negedge clk);
    end
    check(which ? "b_busy_len" : "a_busy_len", nb, which ? 2 : 4);
    check(which ? "b_pending" : "a_pending", which ? q_b.size() : q_a.size(), 0);
  endtask

  logic [15:0] b2b [0:14];

  initial begin
    // reset state
    rst = 1'b0;
    @(negedge clk);
    check("rst_a_outs", {hready_a, hresp_a, busy_a, rdata_a}, 0);
    check("rst_b_outs", {hready_b, hresp_b, busy_b, rdata_b}, 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: write then read
    xfer(1'b0, 16'h3005, 1'b0, 10'h000);
    xfer(1'b0, 16'h2000, 1'b0, 10'h005);
    // 2: id mismatch leaves bank unchanged
    xfer(1'b0, 16'h4008, 1'b1, 10'h000);
    xfer(1'b0, 16'h2000, 1'b0, 10'h005);
    // 3: read-only register
    xfer(1'b0, 16'h3C0F, 1'b1, 10'h000);
    xfer(1'b0, 16'h2C00, 1'b0, 10'h001);

    // 4: back-to-back, data changing every cycle; captures at i=0,5,10
    for (int i = 0; i < 15; i++) b2b[i] = 16'h33FF - 16'(i);
    b2b[0]  = 16'h3011;
    b2b[5]  = 16'h2000;
    b2b[10] = 16'h3409;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      hsel_a = 1'b1;
      data_a = b2b[i];
      @(posedge clk);
      #1;
      if (i == 0)  push(1'b0, 1'b0, 10'h000);
      if (i == 5)  push(1'b0, 1'b0, 10'h011);
      if (i == 10) push(1'b0, 1'b0, 10'h000);
    end
    hsel_a = 1'b0;
    data_a = 16'd0;
    repeat (4) @(negedge clk);
    check("b2b_pending", q_a.size(), 0);
    xfer(1'b0, 16'h2400, 1'b0, 10'h009);

    // 5: reset mid-transfer aborts the write to reg 1
    @(negedge clk);
    hsel_a = 1'b1;
    data_a = 16'h3403;
    @(posedge clk);
    #1;
    hsel_a = 1'b0;
    data_a = 16'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_a_outs", {hready_a, hresp_a, busy_a, rdata_a}, 0);
    check("midrst_b_outs", {hready_b, hresp_b, busy_b, rdata_b}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    xfer(1'b0, 16'h2400, 1'b0, 10'h000);

    // 6: W=0 instance
    xfer(1'b1, 16'h3805, 1'b0, 10'h000);
    xfer(1'b1, 16'h2800, 1'b0, 10'h005);
    xfer(1'b1, 16'h2C00, 1'b0, 10'h001);

    repeat (3) @(negedge clk);
    check("final_q_a", q_a.size(), 0);
    check("final_q_b", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
